// File: rtl/rtc_alarm_clock_pkg.sv
// Shared clock types: field widths, the time record, alarm states and time helpers.
// Pure declarations and functions, no state; no latency.
// No handshakes here, so there is no backpressure.
package clock_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  typedef struct packed {
    logic [HR_W-1:0]  hh;
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
    logic             pm;
  } time_t;

  typedef enum logic {IDLE, RINGING} alarm_state_t;

  // Minutes/seconds 0..59; hours 0..23, or 1..12 in 12h mode.
  function automatic logic valid_time(time_t t, logic mode12);
    logic ok;
    ok = (t.mm <= 6'd59) && (t.ss <= 6'd59);
    if (mode12) ok = ok && (t.hh >= 5'd1) && (t.hh <= 5'd12);
    else        ok = ok && (t.hh <= 5'd23);
    return ok;
  endfunction

  // One-second advance with carries; in 12h mode pm flips on 11->12, not on 12->1.
  function automatic time_t next_time(time_t t, logic mode12);
    time_t n;
    n = t;
    if (t.ss != 6'd59) begin
      n.ss = t.ss + 6'd1;
    end else begin
      n.ss = '0;
      if (t.mm != 6'd59) begin
        n.mm = t.mm + 6'd1;
      end else begin
        n.mm = '0;
        if (mode12) begin
          if (t.hh == 5'd12) begin
            n.hh = 5'd1;
          end else begin
            n.hh = t.hh + 5'd1;
            if (t.hh == 5'd11) n.pm = ~t.pm;
          end
        end else begin
          n.hh = (t.hh == 5'd23) ? 5'd0 : t.hh + 5'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_alarm_clock_if.sv
// Bundle of every control strobe and time/alarm output of the alarm clock.
// Wires only; no latency.
// Strobes are single-cycle and always accepted; no backpressure.
interface rtc_clock_interface;
  logic       run;
  logic       set_valid;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       set_pm;
  logic       alarm_wr;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_pm;
  logic       alarm_en;
  logic       alarm_ack;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_tick;
  logic       alarm_ring;
  logic       set_err;

  modport master (
    output run, set_valid, set_hh, set_mm, set_ss, set_pm,
    output alarm_wr, alarm_hh, alarm_mm, alarm_pm, alarm_en, alarm_ack,
    input  seconds, minutes, hours, pm, sec_tick, alarm_ring, set_err
  );

  modport slave (
    input  run, set_valid, set_hh, set_mm, set_ss, set_pm,
    input  alarm_wr, alarm_hh, alarm_mm, alarm_pm, alarm_en, alarm_ack,
    output seconds, minutes, hours, pm, sec_tick, alarm_ring, set_err
  );
endinterface

// File: rtl/rtc_alarm_clock_tick_gen.sv
// Prescaler: divides clk by TICKS_PER_SEC into a one-per-second tick.
// tick is decoded from the count, so the consumer registers the result on the same edge.
// run=0 freezes the count; clear forces it to 0 and wins over counting.
module tick_gen #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TC = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == TC);

  // Count 0..TC while running, wrapping on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (tick)      cnt <= '0;
    else if (run)       cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/rtc_alarm_clock.sv
// Real-time clock hh:mm:ss (24h or 12h+pm) with a settable alarm, ack and ring timeout.
// Outputs registered: new time, sec_tick and alarm_ring appear on the edge consuming the tick.
// No backpressure: set/alarm/ack strobes are accepted every cycle, bad values flag set_err.
module rtc_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int MODE_12H      = 0,
  parameter int RING_SECS     = 30
) (
  input logic clk,
  input logic reset,
  rtc_clock_interface.slave bus
);
  localparam logic M12 = (MODE_12H != 0);
  localparam int   RW  = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam time_t RESET_T = '{hh: (M12 ? 5'd12 : 5'd0), mm: 6'd0, ss: 6'd0, pm: 1'b0};

  time_t        cur, alarm, set_t, alm_t, nxt;
  alarm_state_t state;
  logic [RW-1:0] ring_cnt;
  logic tick, load, set_ok, alm_ok, adv, hit;
  logic sec_tick_q, set_err_q, ring_q;

  tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (bus.run),
    .clear (load),
    .tick  (tick)
  );

  // Candidate load values (pm forced low in 24h mode), range checks and alarm match.
  always_comb begin
    set_t  = '{hh: bus.set_hh, mm: bus.set_mm, ss: bus.set_ss, pm: (M12 ? bus.set_pm : 1'b0)};
    alm_t  = '{hh: bus.alarm_hh, mm: bus.alarm_mm, ss: 6'd0, pm: (M12 ? bus.alarm_pm : 1'b0)};
    set_ok = valid_time(set_t, M12);
    alm_ok = valid_time(alm_t, M12);
    load   = bus.set_valid && set_ok;
    adv    = tick && !load;
    nxt    = next_time(cur, M12);
    hit    = adv && bus.alarm_en && (nxt == alarm);
  end

  // Time counters, stored alarm, and the sec_tick / set_err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= RESET_T;
      alarm      <= RESET_T;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      sec_tick_q <= adv;
      set_err_q  <= (bus.set_valid && !set_ok) || (bus.alarm_wr && !alm_ok);
      if (load)     cur <= set_t;
      else if (adv) cur <= nxt;
      if (bus.alarm_wr && alm_ok) alarm <= alm_t;
    end
  end

  // Alarm FSM: a new trigger beats ack; ring ends on ack or after RING_SECS ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      ring_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= RINGING;
            ring_cnt <= '0;
            ring_q   <= 1'b1;
          end
        end
        RINGING: begin
          if (hit) begin
            ring_cnt <= '0;
          end else if (bus.alarm_ack) begin
            state  <= IDLE;
            ring_q <= 1'b0;
          end else if (adv) begin
            if (ring_cnt == RING_LAST) begin
              state  <= IDLE;
              ring_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          ring_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.seconds    = cur.ss;
  assign bus.minutes    = cur.mm;
  assign bus.hours      = cur.hh;
  assign bus.pm         = cur.pm;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.set_err    = set_err_q;
  assign bus.alarm_ring = ring_q;
endmodule

// File: tb/tb_rtc_alarm_clock.sv
module tb_rtc_alarm_clock;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rtc_clock_interface ifa ();
  rtc_clock_interface ifb ();

  rtc_alarm_clock #(.TICKS_PER_SEC(4), .MODE_12H(0), .RING_SECS(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  rtc_alarm_clock #(.TICKS_PER_SEC(4), .MODE_12H(1), .RING_SECS(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  logic [17:0] ta, tb;
  assign ta = {ifa.hours, ifa.minutes, ifa.seconds, ifa.pm};
  assign tb = {ifb.hours, ifb.minutes, ifb.seconds, ifb.pm};

  function automatic logic [17:0] tv(input int h, input int m, input int s, input int p);
    return {5'(h), 6'(m), 6'(s), 1'(p)};
  endfunction

  task automatic set_a(input int h, input int m, input int s);
    ifa.set_hh = 5'(h); ifa.set_mm = 6'(m); ifa.set_ss = 6'(s); ifa.set_pm = 1'b0;
    ifa.set_valid = 1'b1;
    @(negedge clk);
    ifa.set_valid = 1'b0;
  endtask

  task automatic set_b(input int h, input int m, input int s, input int p);
    ifb.set_hh = 5'(h); ifb.set_mm = 6'(m); ifb.set_ss = 6'(s); ifb.set_pm = 1'(p);
    ifb.set_valid = 1'b1;
    @(negedge clk);
    ifb.set_valid = 1'b0;
  endtask

  task automatic run_a(input int n);
    ifa.run = 1'b1;
    repeat (n) @(negedge clk);
    ifa.run = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++; if (ta !== tv(0,0,0,0)) begin miscompares++; $display("FAIL reset_time24: got %h want %h", ta, tv(0,0,0,0)); end
    vectors++; if (tb !== tv(12,0,0,0)) begin miscompares++; $display("FAIL reset_time12: got %h want %h", tb, tv(12,0,0,0)); end
    vectors++; if ({ifa.sec_tick, ifa.alarm_ring, ifa.set_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {ifa.sec_tick, ifa.alarm_ring, ifa.set_err}); end
  endtask

  task automatic test_basic_count;
    int ticks, first;
    ticks = 0; first = 0;
    ifa.run = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (ifa.sec_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    ifa.run = 1'b0;
    vectors++; if (first !== 4) begin miscompares++; $display("FAIL first_tick_cycle: got %0d want 4", first); end
    vectors++; if (ticks !== 60) begin miscompares++; $display("FAIL tick_count: got %0d want 60", ticks); end
    vectors++; if (ta !== tv(0,1,0,0)) begin miscompares++; $display("FAIL count_time: got %h want %h", ta, tv(0,1,0,0)); end
  endtask

  task automatic test_hold;
    int ticks;
    ticks = 0;
    run_a(2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifa.sec_tick) ticks++;
    end
    vectors++; if (ticks !== 0) begin miscompares++; $display("FAIL hold_ticks: got %0d want 0", ticks); end
    vectors++; if (ta !== tv(0,1,0,0)) begin miscompares++; $display("FAIL hold_time: got %h want %h", ta, tv(0,1,0,0)); end
    ifa.run = 1'b1;
    @(negedge clk);
    vectors++; if (ifa.sec_tick !== 1'b0) begin miscompares++; $display("FAIL hold_resume_early: got %b want 0", ifa.sec_tick); end
    @(negedge clk);
    ifa.run = 1'b0;
    vectors++; if (ifa.sec_tick !== 1'b1) begin miscompares++; $display("FAIL hold_resume_tick: got %b want 1", ifa.sec_tick); end
    vectors++; if (ta !== tv(0,1,1,0)) begin miscompares++; $display("FAIL hold_resume_time: got %h want %h", ta, tv(0,1,1,0)); end
  endtask

  task automatic test_set_err;
    set_a(12, 61, 0);
    vectors++; if (ifa.set_err !== 1'b1) begin miscompares++; $display("FAIL set_err_pulse: got %b want 1", ifa.set_err); end
    vectors++; if (ta !== tv(0,1,1,0)) begin miscompares++; $display("FAIL set_err_time: got %h want %h", ta, tv(0,1,1,0)); end
    @(negedge clk);
    vectors++; if (ifa.set_err !== 1'b0) begin miscompares++; $display("FAIL set_err_width: got %b want 0", ifa.set_err); end
    ifa.alarm_hh = 5'd7; ifa.alarm_mm = 6'd30; ifa.alarm_wr = 1'b1;
    @(negedge clk);
    ifa.alarm_wr = 1'b0;
    vectors++; if (ifa.set_err !== 1'b0) begin miscompares++; $display("FAIL alarm_wr_ok: got %b want 0", ifa.set_err); end
    ifa.alarm_hh = 5'd24; ifa.alarm_mm = 6'd0; ifa.alarm_wr = 1'b1;
    @(negedge clk);
    ifa.alarm_wr = 1'b0;
    vectors++; if (ifa.set_err !== 1'b1) begin miscompares++; $display("FAIL alarm_wr_reject: got %b want 1", ifa.set_err); end
  endtask

  task automatic test_set_on_tick;
    set_a(0, 0, 0);
    ifa.run = 1'b1;
    repeat (3) @(negedge clk);
    ifa.set_hh = 5'd10; ifa.set_mm = 6'd20; ifa.set_ss = 6'd30; ifa.set_valid = 1'b1;
    @(negedge clk);
    ifa.set_valid = 1'b0;
    vectors++; if (ta !== tv(10,20,30,0)) begin miscompares++; $display("FAIL set_on_tick_time: got %h want %h", ta, tv(10,20,30,0)); end
    vectors++; if (ifa.sec_tick !== 1'b0) begin miscompares++; $display("FAIL set_on_tick_suppress: got %b want 0", ifa.sec_tick); end
    repeat (3) @(negedge clk);
    vectors++; if (ta !== tv(10,20,30,0)) begin miscompares++; $display("FAIL set_clears_prescaler: got %h want %h", ta, tv(10,20,30,0)); end
    @(negedge clk);
    ifa.run = 1'b0;
    vectors++; if (ta !== tv(10,20,31,0)) begin miscompares++; $display("FAIL set_then_tick: got %h want %h", ta, tv(10,20,31,0)); end
  endtask

  task automatic test_rollover_24;
    set_a(23, 59, 58);
    vectors++; if (ta !== tv(23,59,58,0)) begin miscompares++; $display("FAIL roll24_load: got %h want %h", ta, tv(23,59,58,0)); end
    run_a(4);
    vectors++; if (ta !== tv(23,59,59,0)) begin miscompares++; $display("FAIL roll24_step1: got %h want %h", ta, tv(23,59,59,0)); end
    run_a(4);
    vectors++; if (ta !== tv(0,0,0,0)) begin miscompares++; $display("FAIL roll24_wrap: got %h want %h", ta, tv(0,0,0,0)); end
  endtask

  task automatic test_rollover_12;
    set_b(0, 0, 0, 0);
    vectors++; if (ifb.set_err !== 1'b1) begin miscompares++; $display("FAIL roll12_reject0: got %b want 1", ifb.set_err); end
    set_b(13, 0, 0, 0);
    vectors++; if (ifb.set_err !== 1'b1) begin miscompares++; $display("FAIL roll12_reject13: got %b want 1", ifb.set_err); end
    vectors++; if (tb !== tv(12,0,0,0)) begin miscompares++; $display("FAIL roll12_unchanged: got %h want %h", tb, tv(12,0,0,0)); end
    set_b(11, 59, 59, 0);
    ifb.run = 1'b1; repeat (4) @(negedge clk); ifb.run = 1'b0;
    vectors++; if (tb !== tv(12,0,0,1)) begin miscompares++; $display("FAIL roll12_noon: got %h want %h", tb, tv(12,0,0,1)); end
    set_b(12, 59, 59, 1);
    ifb.run = 1'b1; repeat (4) @(negedge clk); ifb.run = 1'b0;
    vectors++; if (tb !== tv(1,0,0,1)) begin miscompares++; $display("FAIL roll12_one: got %h want %h", tb, tv(1,0,0,1)); end
  endtask

  task automatic test_alarm_ack;
    ifa.alarm_en = 1'b1;
    set_a(7, 29, 59);
    run_a(4);
    vectors++; if (ta !== tv(7,30,0,0)) begin miscompares++; $display("FAIL alarm_time: got %h want %h", ta, tv(7,30,0,0)); end
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL alarm_trigger: got %b want 1", ifa.alarm_ring); end
    ifa.alarm_ack = 1'b1;
    @(negedge clk);
    ifa.alarm_ack = 1'b0;
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL alarm_ack: got %b want 0", ifa.alarm_ring); end
  endtask

  task automatic test_alarm_timeout;
    set_a(7, 29, 59);
    run_a(4);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL timeout_enter: got %b want 1", ifa.alarm_ring); end
    run_a(4);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL timeout_tick1: got %b want 1", ifa.alarm_ring); end
    repeat (20) @(negedge clk);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL timeout_hold: got %b want 1", ifa.alarm_ring); end
    run_a(4);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL timeout_tick2: got %b want 1", ifa.alarm_ring); end
    run_a(3);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL timeout_pre3: got %b want 1", ifa.alarm_ring); end
    run_a(1);
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL timeout_tick3: got %b want 0", ifa.alarm_ring); end
    vectors++; if (ta !== tv(7,30,3,0)) begin miscompares++; $display("FAIL timeout_time: got %h want %h", ta, tv(7,30,3,0)); end
  endtask

  task automatic test_alarm_disabled;
    ifa.alarm_en = 1'b0;
    set_a(7, 29, 59);
    run_a(4);
    ifa.alarm_en = 1'b1;
    vectors++; if (ta !== tv(7,30,0,0)) begin miscompares++; $display("FAIL disabled_time: got %h want %h", ta, tv(7,30,0,0)); end
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL disabled_ring: got %b want 0", ifa.alarm_ring); end
    set_a(7, 30, 0);
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL set_on_alarm: got %b want 0", ifa.alarm_ring); end
    run_a(4);
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL set_on_alarm_next: got %b want 0", ifa.alarm_ring); end
  endtask

  task automatic test_reset_mid_ring;
    set_a(7, 29, 59);
    run_a(4);
    vectors++; if (ifa.alarm_ring !== 1'b1) begin miscompares++; $display("FAIL midring_enter: got %b want 1", ifa.alarm_ring); end
    ifa.run = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ifa.run = 1'b0;
    vectors++; if (ifa.alarm_ring !== 1'b0) begin miscompares++; $display("FAIL midring_ring: got %b want 0", ifa.alarm_ring); end
    vectors++; if (ta !== tv(0,0,0,0)) begin miscompares++; $display("FAIL midring_time: got %h want %h", ta, tv(0,0,0,0)); end
    vectors++; if (tb !== tv(12,0,0,0)) begin miscompares++; $display("FAIL midring_time12: got %h want %h", tb, tv(12,0,0,0)); end
    vectors++; if (ifa.sec_tick !== 1'b0) begin miscompares++; $display("FAIL midring_tick: got %b want 0", ifa.sec_tick); end
  endtask

  initial begin
    ifa.run = 0; ifa.set_valid = 0; ifa.set_hh = 0; ifa.set_mm = 0; ifa.set_ss = 0; ifa.set_pm = 0;
    ifa.alarm_wr = 0; ifa.alarm_hh = 0; ifa.alarm_mm = 0; ifa.alarm_pm = 0; ifa.alarm_en = 0; ifa.alarm_ack = 0;
    ifb.run = 0; ifb.set_valid = 0; ifb.set_hh = 0; ifb.set_mm = 0; ifb.set_ss = 0; ifb.set_pm = 0;
    ifb.alarm_wr = 0; ifb.alarm_hh = 0; ifb.alarm_mm = 0; ifb.alarm_pm = 0; ifb.alarm_en = 0; ifb.alarm_ack = 0;
    test_reset;
    test_basic_count;
    test_hold;
    test_set_err;
    test_set_on_tick;
    test_rollover_24;
    test_rollover_12;
    test_alarm_ack;
    test_alarm_timeout;
    test_alarm_disabled;
    test_reset_mid_ring;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
